gs_slice_packer: RTL and testbench

Double-buffered grayscale packer upstream of the LED-driver serializer. Accepts one voxel slice of 24-bit RGB pixels from the HDMI decoder, expands each 8-bit colour to 16-bit grayscale, and assembles one 769-bit grayscale latch word per SDO lane. The serializer then fetches the word bit-by-bit while the next slice fills the other bank.

---
 rtl/gs_pkg.sv | 32 +++
 rtl/gs_bank.sv | 54 +++++
 rtl/gs_slice_packer.sv | 175 +++++++++++++++++
 tb/tb_gs_slice_packer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared constants, state type and colour helpers for the grayscale slice packer.
package gs_pkg;

  localparam int LATCH_SIZE    = 769;
  localparam int GS_BITS       = 16;
  localparam int CH_PER_LED    = 3;
  localparam int LEDS_PER_CHIP = 16;
  localparam int LED_BITS      = GS_BITS * CH_PER_LED;
  localparam int IDX_W         = $clog2(LATCH_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    COL_R = 2'd0,
    COL_G = 2'd1,
    COL_B = 2'd2
  } colour_t;

  // Bit replication maps 0x00->0x0000 and 0xFF->0xFFFF exactly.
  function automatic logic [GS_BITS-1:0] expand8to16(input logic [7:0] c);
    return {c, c};
  endfunction

  function automatic int chan_offset(input int led, input colour_t colour);
    return led * LED_BITS + int'(colour) * GS_BITS;
  endfunction

endpackage

// File: rtl/gs_bank.sv
// One grayscale bank: LANES lane words of LEDS x 48 bits, written one LED
// at a time and read back one bit per lane through a registered port.
module gs_bank
  import gs_pkg::*;
#(
  parameter  int LANES  = 4,
  parameter  int LEDS   = LEDS_PER_CHIP,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int LED_W  = (LEDS > 1) ? $clog2(LEDS) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [LANE_W-1:0]   wr_lane,
  input  logic [LED_W-1:0]    wr_led,
  input  logic [LED_BITS-1:0] wr_data,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [LANES-1:0]    rd_bits
);

  localparam int WORDS  = LANES * LEDS;
  localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W  = $clog2(LED_BITS);

  logic [LED_BITS-1:0] mem [WORDS];
  logic [ADDR_W-1:0]   wr_addr;
  logic [LED_W-1:0]    rd_led;
  logic [OFF_W-1:0]    rd_off;

  assign wr_addr = ADDR_W'(int'(wr_lane) * LEDS + int'(wr_led));

  // Indices past the data field decode to LED 0; the top masks them to zero.
  always_comb begin
    rd_led = '0;
    rd_off = '0;
    if (int'(rd_idx) < LEDS * LED_BITS) begin
      rd_led = LED_W'(int'(rd_idx) / LED_BITS);
      rd_off = OFF_W'(int'(rd_idx) % LED_BITS);
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ---- read stage p1 ----
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      rd_bits[l] <= mem[ADDR_W'(l * LEDS + int'(rd_led))][rd_off];
    end
  end

endmodule

// File: rtl/gs_slice_packer.sv
// Double-buffered packer: fills one bank with a slice of RGB pixels expanded
// to 16-bit grayscale while the serializer reads the other bank bit by bit.
module gs_slice_packer
  import gs_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int LEDS_PER_LANE = LEDS_PER_CHIP
) (
  input  logic             CLK_10M,
  input  logic             nReset,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [23:0]      pix_rgb,
  input  logic             pix_sof,
  output logic             gs_valid,
  input  logic             gs_ack,
  input  logic [9:0]       gs_bit_idx,
  output logic [LANES-1:0] gs_bits,
  output logic             sof_err
);

  localparam int SLICE  = LANES * LEDS_PER_LANE;
  localparam int K_W    = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LED_W  = (LEDS_PER_LANE > 1) ? $clog2(LEDS_PER_LANE) : 1;
  localparam int R_OFF  = chan_offset(0, COL_R);
  localparam int G_OFF  = chan_offset(0, COL_G);
  localparam int B_OFF  = chan_offset(0, COL_B);

  localparam logic [K_W-1:0]   K_LAST  = K_W'(SLICE - 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(LEDS_PER_LANE * LED_BITS);

  wr_state_t           state, state_n;
  logic [K_W-1:0]      k, k_n, k_wr;
  logic                wr_bank, wr_bank_n;
  logic                rd_bank, rd_bank_n;
  logic [1:0]          full, full_n, full_acked;
  logic                sof_err_n, ready_n;
  logic                accept, ack_take, we;
  logic [LANE_W-1:0]   wr_lane;
  logic [LED_W-1:0]    wr_led;
  logic [LED_BITS-1:0] wr_data;
  logic                rd_en_p1, rd_sel_p1;
  logic [LANES-1:0]    bits0_p1, bits1_p1;

  assign accept   = pix_valid & pix_ready;
  assign gs_valid = full[rd_bank];
  assign ack_take = gs_ack & gs_valid;

  // A sof pixel always lands in slot 0, whatever the running count says.
  assign k_wr    = pix_sof ? '0 : k;
  assign wr_lane = LANE_W'(int'(k_wr) / LEDS_PER_LANE);
  assign wr_led  = LED_W'(int'(k_wr) % LEDS_PER_LANE);

  always_comb begin
    wr_data                  = '0;
    wr_data[R_OFF+:GS_BITS]  = expand8to16(pix_rgb[23:16]);
    wr_data[G_OFF+:GS_BITS]  = expand8to16(pix_rgb[15:8]);
    wr_data[B_OFF+:GS_BITS]  = expand8to16(pix_rgb[7:0]);
  end

  always_comb begin
    full_acked = full;
    if (ack_take) begin
      full_acked[rd_bank] = 1'b0;
    end

    state_n   = state;
    k_n       = k;
    wr_bank_n = wr_bank;
    rd_bank_n = rd_bank ^ ack_take;
    full_n    = full_acked;
    sof_err_n = sof_err;
    we        = 1'b0;

    // Bank release is judged after this cycle's ack, so a same-edge ack
    // frees the other bank for immediate reuse.
    case (state)
      IDLE: begin
        if (accept) begin
          if (pix_sof) begin
            we      = 1'b1;
            k_n     = K_W'(1);
            state_n = FILL;
          end else begin
            sof_err_n = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          we = 1'b1;
          if (pix_sof) begin
            sof_err_n = 1'b1;
            k_n       = K_W'(1);
          end else if (k == K_LAST) begin
            full_n[wr_bank] = 1'b1;
            k_n             = '0;
            if (!full_acked[~wr_bank]) begin
              wr_bank_n = ~wr_bank;
              state_n   = IDLE;
            end else begin
              state_n = STALL;
            end
          end else begin
            k_n = k + K_W'(1);
          end
        end
      end
      STALL: begin
        if (!full_acked[~wr_bank]) begin
          wr_bank_n = ~wr_bank;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    ready_n = (state_n != STALL);
  end

  always_ff @(posedge CLK_10M or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      k         <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      sof_err   <= 1'b0;
      pix_ready <= 1'b0;
      rd_en_p1  <= 1'b0;
      rd_sel_p1 <= 1'b0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      wr_bank   <= wr_bank_n;
      rd_bank   <= rd_bank_n;
      full      <= full_n;
      sof_err   <= sof_err_n;
      pix_ready <= ready_n;
      // ---- read stage p1: select follows the post-ack read bank ----
      rd_en_p1  <= full_n[rd_bank_n] && (gs_bit_idx < IDX_END);
      rd_sel_p1 <= rd_bank_n;
    end
  end

  gs_bank #(
    .LANES (LANES),
    .LEDS  (LEDS_PER_LANE)
  ) u_bank0 (
    .clk     (CLK_10M),
    .we      (we & ~wr_bank),
    .wr_lane (wr_lane),
    .wr_led  (wr_led),
    .wr_data (wr_data),
    .rd_idx  (gs_bit_idx),
    .rd_bits (bits0_p1)
  );

  gs_bank #(
    .LANES (LANES),
    .LEDS  (LEDS_PER_LANE)
  ) u_bank1 (
    .clk     (CLK_10M),
    .we      (we & wr_bank),
    .wr_lane (wr_lane),
    .wr_led  (wr_led),
    .wr_data (wr_data),
    .rd_idx  (gs_bit_idx),
    .rd_bits (bits1_p1)
  );

  assign gs_bits = rd_en_p1 ? (rd_sel_p1 ? bits1_p1 : bits0_p1) : '0;

endmodule

// File: tb/tb_gs_slice_packer.sv
// Directed bench for gs_slice_packer: slice fill, bank ping-pong, framing
// errors, simultaneous ack/last pixel and asynchronous reset.
module tb_gs_slice_packer;

  logic        clk;
  logic        nReset;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_rgb;
  logic        pix_sof;
  logic        gs_valid;
  logic        gs_ack;
  logic [9:0]  gs_bit_idx;
  logic [3:0]  gs_bits;
  logic        sof_err;

  int n_tests = 0;
  int n_fail  = 0;

  gs_slice_packer #(
    .LANES         (4),
    .LEDS_PER_LANE (16)
  ) dut (
    .CLK_10M    (clk),
    .nReset     (nReset),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_rgb    (pix_rgb),
    .pix_sof    (pix_sof),
    .gs_valid   (gs_valid),
    .gs_ack     (gs_ack),
    .gs_bit_idx (gs_bit_idx),
    .gs_bits    (gs_bits),
    .sof_err    (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          lane;
    int          led;
    int          colour;
    logic [15:0] exp;
  } field_vec_t;

  field_vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stimulus patterns per slice number; colour bytes are R, G, B.
  function automatic logic [23:0] pix_val(input int s, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    case (s)
      1:       pix_val = {kb, 8'h00, 8'hFF};
      2:       pix_val = {kb + 8'h40, 8'h55, kb};
      3:       pix_val = {8'h80, kb, 8'h01};
      4:       pix_val = {8'hC3, kb ^ 8'h5A, kb + 8'h11};
      5:       pix_val = 24'hEEEEEE;
      default: pix_val = {kb, kb, ~kb};
    endcase
  endfunction

  function automatic logic [15:0] exp_field(input int s, input int lane, input int led,
                                            input int colour);
    logic [23:0] p;
    logic [7:0]  b;
    p = pix_val(s, lane * 16 + led);
    case (colour)
      0:       b = p[23:16];
      1:       b = p[15:8];
      default: b = p[7:0];
    endcase
    return {b, b};
  endfunction

  task automatic send_pixel(input logic [23:0] rgb, input logic sof);
    int waitc;
    waitc     = 0;
    pix_valid = 1'b1;
    pix_rgb   = rgb;
    pix_sof   = sof;
    while (!pix_ready && waitc < 50) begin
      tick();
      waitc++;
    end
    if (!pix_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL pix_ready_timeout: got 0, expected 1 within 50 cycles");
    end
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_range(input int s, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      send_pixel(pix_val(s, k), (k == 0));
    end
  endtask

  task automatic read_field(input int lane, input int base, output logic [15:0] val);
    logic [1:0] ln;
    ln  = 2'(lane);
    val = '0;
    for (int i = 0; i < 16; i++) begin
      gs_bit_idx = 10'(base + i);
      tick();
      val = {gs_bits[ln], val[15:1]};
    end
  endtask

  task automatic check_field(input string name, input int s, input int lane, input int led,
                             input int colour);
    logic [15:0] v;
    read_field(lane, led * 48 + colour * 16, v);
    check(name, 32'(v), 32'(exp_field(s, lane, led, colour)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;

    vecs[0] = '{"s1_l1_led0_R",  1, 0,  0, 16'h1010};
    vecs[1] = '{"s1_l1_led0_G",  1, 0,  1, 16'h0000};
    vecs[2] = '{"s1_l1_led0_B",  1, 0,  2, 16'hFFFF};
    vecs[3] = '{"s1_l0_led0_R",  0, 0,  0, 16'h0000};
    vecs[4] = '{"s1_l0_led7_R",  0, 7,  0, 16'h0707};
    vecs[5] = '{"s1_l2_led5_R",  2, 5,  0, 16'h2525};
    vecs[6] = '{"s1_l3_led15_R", 3, 15, 0, 16'h3F3F};
    vecs[7] = '{"s1_l3_led15_B", 3, 15, 2, 16'hFFFF};

    nReset     = 1'b0;
    pix_valid  = 1'b0;
    pix_rgb    = '0;
    pix_sof    = 1'b0;
    gs_ack     = 1'b0;
    gs_bit_idx = '0;

    repeat (3) tick();
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_gs_valid",  32'(gs_valid),  32'd0);
    check("rst_gs_bits",   32'(gs_bits),   32'd0);
    check("rst_sof_err",   32'(sof_err),   32'd0);
    nReset = 1'b1;
    tick();
    check("rel_pix_ready", 32'(pix_ready), 32'd1);

    // Slice 1
    send_range(1, 0, 62);
    check("s1_not_early", 32'(gs_valid), 32'd0);
    send_range(1, 63, 63);
    check("s1_gs_valid",  32'(gs_valid),  32'd1);
    check("s1_pix_ready", 32'(pix_ready), 32'd1);
    check("s1_sof_err",   32'(sof_err),   32'd0);
    for (int i = 0; i < 8; i++) begin
      read_field(vecs[i].lane, vecs[i].led * 48 + vecs[i].colour * 16, v);
      check(vecs[i].name, 32'(v), 32'(vecs[i].exp));
    end
    gs_bit_idx = 10'd768;
    tick();
    check("idx768_zero", 32'(gs_bits), 32'd0);
    gs_bit_idx = 10'd1000;
    tick();
    check("idx1000_zero", 32'(gs_bits), 32'd0);

    // Slice 2 fills the second bank; slice 3 must then stall
    send_range(2, 0, 63);
    check("s2_stall_ready", 32'(pix_ready), 32'd0);
    check("s2_valid",       32'(gs_valid),  32'd1);
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_rgb   = pix_val(3, 0);
    tick();
    check("s3_first_blocked", 32'(pix_ready), 32'd0);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    check_field("stall_reads_s1", 1, 1, 0, 0);
    gs_ack = 1'b1;
    tick();
    gs_ack = 1'b0;
    check("ack_ready",  32'(pix_ready), 32'd1);
    check("ack_valid",  32'(gs_valid),  32'd1);
    check_field("s2_l1_led0_R",  2, 1, 0,  0);
    check_field("s2_l3_led15_R", 2, 3, 15, 0);
    check_field("s2_l0_led4_G",  2, 0, 4,  1);

    // Slice 3 with ack on the same edge as its last pixel
    send_range(3, 0, 62);
    check("s3_prev_valid", 32'(gs_valid), 32'd1);
    pix_valid = 1'b1;
    pix_sof   = 1'b0;
    pix_rgb   = pix_val(3, 63);
    gs_ack    = 1'b1;
    tick();
    pix_valid = 1'b0;
    gs_ack    = 1'b0;
    check("sim_valid", 32'(gs_valid),  32'd1);
    check("sim_ready", 32'(pix_ready), 32'd1);
    check_field("s3_l2_led4_G",  3, 2, 4,  1);
    check_field("s3_l3_led15_R", 3, 3, 15, 0);
    check_field("s3_l1_led2_B",  3, 1, 2,  2);
    gs_bit_idx = 10'd0;
    gs_ack     = 1'b1;
    tick();
    gs_ack = 1'b0;
    check("empty_valid", 32'(gs_valid), 32'd0);
    check("empty_bits",  32'(gs_bits),  32'd0);

    // sof at k=10 restarts the slice
    send_range(5, 0, 9);
    send_pixel(pix_val(4, 0), 1'b1);
    check("restart_sof_err", 32'(sof_err), 32'd1);
    send_range(4, 1, 62);
    check("restart_not_early", 32'(gs_valid), 32'd0);
    send_range(4, 63, 63);
    check("restart_valid", 32'(gs_valid), 32'd1);
    check_field("s4_l0_led0_G",  4, 0, 0,  1);
    check_field("s4_l0_led9_B",  4, 0, 9,  2);
    check_field("s4_l3_led15_G", 4, 3, 15, 1);
    check("sof_err_sticky", 32'(sof_err), 32'd1);

    // Reset mid-fill (k=30) while a slice is being read
    send_range(5, 0, 29);
    check("pre_rst_valid", 32'(gs_valid), 32'd1);
    nReset = 1'b0;
    #1;
    check("midrst_valid",   32'(gs_valid),  32'd0);
    check("midrst_ready",   32'(pix_ready), 32'd0);
    check("midrst_bits",    32'(gs_bits),   32'd0);
    check("midrst_sof_err", 32'(sof_err),   32'd0);
    repeat (2) tick();
    nReset = 1'b1;
    tick();
    check("rerel_ready", 32'(pix_ready), 32'd1);
    check("rerel_valid", 32'(gs_valid),  32'd0);

    // Pixel before any sof is dropped
    send_pixel(pix_val(6, 5), 1'b0);
    check("nosof_err",   32'(sof_err),  32'd1);
    check("nosof_valid", 32'(gs_valid), 32'd0);
    send_range(6, 0, 63);
    check("s6_valid", 32'(gs_valid), 32'd1);
    check_field("s6_l1_led3_B",  6, 1, 3, 2);
    check_field("s6_l2_led0_G",  6, 2, 0, 1);
    check_field("s6_l3_led8_R",  6, 3, 8, 0);
    check_field("s6_l0_led0_R",  6, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
